// File: rtl/lcd_write_driver_pkg.sv
// Shared definitions for the HD44780-style LCD write driver: FSM states,
// init sequence and the command codes that need the long execution wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_E_HIGH    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } state_t;

  localparam int INIT_LEN = 7;

  // Entry 0 sits in the least significant byte.
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMD = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38, 8'h38
  };

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  // Clear-class commands (rs=0, bits [7:1] zero) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:1] == CLEAR[7:1]);
  endfunction

endpackage

// File: rtl/lcd_write_driver_if.sv
// Byte handshake between the LCD text/tick logic (master) and the driver (slave).
interface lcd_write_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_write_driver_phase_timer.sv
// Phase length timer: loads a cycle count, counts down, and flags the last
// cycle of the phase. It parks at 1 rather than wrapping.
module lcd_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_write_driver.sv
// HD44780 8-bit write driver: power-on init sequence, then open-loop timed
// command/data writes accepted over a valid/ready handshake.
module lcd_write_driver
  import lcd_pkg::*;
#(
  parameter int T_POWERUP_CYC  = 375000,
  parameter int T_SETUP_CYC    = 2,
  parameter int T_E_HIGH_CYC   = 12,
  parameter int T_HOLD_CYC     = 2,
  parameter int T_CMD_WAIT_CYC = 1000,
  parameter int T_CLR_WAIT_CYC = 41000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_write_driver_if.slave  up,
  output logic               init_done,
  output logic               busy,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_e,
  output logic [7:0]         lcd_data
);

  localparam int T_MAX = (T_POWERUP_CYC > T_CLR_WAIT_CYC) ? T_POWERUP_CYC : T_CLR_WAIT_CYC;
  localparam int CNT_W = $clog2(T_MAX + 1);

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic             accept;
  logic             phase_done;
  logic             timer_load;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] timer_val;

  assign lcd_rw = 1'b0;

  lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (phase_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_POWERUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_POWERUP:   if (phase_done) state_nxt = ST_INIT_LOAD;
      ST_INIT_LOAD: state_nxt = ST_SETUP;
      ST_SETUP:     if (phase_done) state_nxt = ST_E_HIGH;
      ST_E_HIGH:    if (phase_done) state_nxt = ST_HOLD;
      ST_HOLD:      if (phase_done) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (phase_done) begin
          state_nxt = (!init_done && (idx != 3'(INIT_LEN - 1))) ? ST_INIT_LOAD : ST_IDLE;
        end
      end
      ST_IDLE:      if (up.in_valid) state_nxt = ST_SETUP;
      default:      state_nxt = ST_POWERUP;
    endcase
  end

  // Every state change reloads the timer with the length of the phase being entered.
  always_comb begin
    up.in_ready = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    accept      = (state == ST_IDLE) && up.in_valid;
    case (state_nxt)
      ST_POWERUP: phase_len = CNT_W'(T_POWERUP_CYC);
      ST_SETUP:   phase_len = CNT_W'(T_SETUP_CYC);
      ST_E_HIGH:  phase_len = CNT_W'(T_E_HIGH_CYC);
      ST_HOLD:    phase_len = CNT_W'(T_HOLD_CYC);
      ST_WAIT:    phase_len = is_long_cmd(lcd_rs, lcd_data) ? CNT_W'(T_CLR_WAIT_CYC)
                                                            : CNT_W'(T_CMD_WAIT_CYC);
      default:    phase_len = CNT_W'(1);
    endcase
    timer_load = rst || (state_nxt != state);
    timer_val  = rst ? CNT_W'(T_POWERUP_CYC) : phase_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      init_done <= 1'b0;
      idx       <= '0;
    end else begin
      lcd_e <= (state_nxt == ST_E_HIGH);
      if (state == ST_INIT_LOAD) begin
        lcd_rs   <= 1'b0;
        lcd_data <= INIT_CMD[idx];
      end else if (accept) begin
        lcd_rs   <= up.in_rs;
        lcd_data <= up.in_data;
      end
      if ((state == ST_WAIT) && phase_done && !init_done) begin
        if (idx == 3'(INIT_LEN - 1)) begin
          init_done <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_driver.sv
// Self-checking bench for lcd_write_driver with shortened timing parameters.
module tb_lcd_write_driver;

  localparam int T_PU  = 50;
  localparam int T_S   = 2;
  localparam int T_E   = 4;
  localparam int T_H   = 2;
  localparam int T_CMD = 10;
  localparam int T_CLR = 30;

  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int      cyc = 0;
  int      n_tests = 0;
  int      n_fail = 0;
  bit      mon_en = 1'b0;
  int      last_fall = -1000;
  int      last_change = 0;
  int      rise_c = 0;
  logic    prev_e = 1'b0;
  logic [8:0] prev_bus = '0;
  int      m_rise = 0;
  int      m_wait = 0;
  strobe_t strobes[$];

  lcd_write_driver_if bus ();

  lcd_write_driver #(
    .T_POWERUP_CYC  (T_PU),
    .T_SETUP_CYC    (T_S),
    .T_E_HIGH_CYC   (T_E),
    .T_HOLD_CYC     (T_H),
    .T_CMD_WAIT_CYC (T_CMD),
    .T_CLR_WAIT_CYC (T_CLR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (bus),
    .init_done (init_done),
    .busy      (busy),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference rule: clear-class command (rs=0, byte 0x00/0x01) waits long.
  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (rs == 1'b0 && d < 8'd2) ? T_CLR : T_CMD;
  endfunction

  // Pin monitor: records strobes and checks setup/hold and invariants.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("lcd_rw_zero", lcd_rw, 0);
      chk("busy_vs_ready", busy, !bus.in_ready);
      if ({lcd_rs, lcd_data} !== prev_bus) begin
        chk("bus_change_while_e", lcd_e, 0);
        if (cyc - last_fall < T_H) chk("hold_cycles", cyc - last_fall, T_H);
        last_change = cyc;
      end
      if (lcd_e && !prev_e) begin
        rise_c = cyc;
        if (cyc - last_change < T_S) chk("setup_cycles", cyc - last_change, T_S);
      end
      if (!lcd_e && prev_e) begin
        last_fall = cyc;
        strobes.push_back('{rise_c, cyc, lcd_rs, lcd_data});
      end
    end
    prev_e   = lcd_e;
    prev_bus = {lcd_rs, lcd_data};
  end

  task automatic get_strobe(output strobe_t s);
    int n = 0;
    while (strobes.size() == 0 && n < 3000) begin
      tick();
      n++;
    end
    if (strobes.size() == 0) begin
      chk("strobe_timeout", strobes.size(), 1);
      s = '{0, 0, 1'b0, 8'h00};
    end else begin
      s = strobes.pop_front();
    end
  endtask

  task automatic check_init(input int z);
    int r, d, n;
    strobe_t s;
    logic [7:0] seq [7];
    seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    r = z + T_PU + 1 + T_S;
    for (int i = 0; i < 7; i++) begin
      get_strobe(s);
      chk("init_rise", s.rise, r);
      chk("init_width", s.fall - s.rise, T_E);
      chk("init_rs", s.rs, 0);
      chk("init_data", s.data, seq[i]);
      if (i < 6) r = r + T_E + T_H + wait_of(1'b0, seq[i]) + 1 + T_S;
    end
    d = r + T_E + T_H + wait_of(1'b0, seq[6]);
    n = 0;
    while (cyc < d - 1 && n < 5000) begin
      tick();
      n++;
    end
    chk("init_done_early", init_done, 0);
    tick();
    chk("init_done_cycle", cyc, d);
    chk("init_done_rise", init_done, 1);
    m_rise = r;
    m_wait = wait_of(1'b0, seq[6]);
  endtask

  // Present one byte, hold it until accepted, and check accept time and strobe.
  task automatic xfer(input logic rs, input logic [7:0] d, output int acc);
    int p, n, idle_start, exp_acc;
    strobe_t s;
    p = cyc;
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_data  = d;
    acc = -1;
    n = 0;
    while (n < 5000) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    idle_start = m_rise + T_E + T_H + m_wait;
    exp_acc = ((p > idle_start) ? p : idle_start) + 1;
    chk("accept_cycle", acc, exp_acc);
    get_strobe(s);
    chk("strobe_rise", s.rise, exp_acc + T_S);
    chk("strobe_width", s.fall - s.rise, T_E);
    chk("strobe_rs", s.rs, rs);
    chk("strobe_data", s.data, d);
    m_rise = exp_acc + T_S;
    m_wait = wait_of(rs, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    int acc, prev_acc, z, n;

    vecs[0] = '{1'b1, 8'h41, T_CMD};
    vecs[1] = '{1'b0, 8'h01, T_CLR};
    vecs[2] = '{1'b0, 8'h80, T_CMD};
    vecs[3] = '{1'b0, 8'h00, T_CLR};
    vecs[4] = '{1'b1, 8'h00, T_CMD};
    vecs[5] = '{1'b0, 8'h0C, T_CMD};
    vecs[6] = '{1'b1, 8'h01, T_CMD};
    vecs[7] = '{1'b0, 8'h06, T_CMD};

    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_data", lcd_data, 0);
    rst = 1'b0;
    z = cyc;
    last_change = cyc;
    mon_en = 1'b1;

    // First table byte is offered during init and must wait for init_done.
    fork
      check_init(z);
      xfer(vecs[0].rs, vecs[0].data, acc);
    join
    prev_acc = acc;
    for (int i = 1; i < 8; i++) begin
      xfer(vecs[i].rs, vecs[i].data, acc);
      chk("table_period", acc - prev_acc, 1 + T_S + T_E + T_H + vecs[i-1].wait_cyc);
      prev_acc = acc;
    end

    for (int i = 0; i < 16; i++) begin
      logic       rs;
      logic [7:0] d;
      int         gap;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       d = 8'h00;
        1:       d = 8'h01;
        default: d = 8'($urandom_range(4, 255));
      endcase
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      repeat (gap) tick();
      xfer(rs, d, acc);
    end

    // Reset during the enable pulse of a data write.
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = 8'h55;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (lcd_e !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("e_high_before_rst", lcd_e, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_lcd_e", lcd_e, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_lcd_data", lcd_data, 0);
    chk("midrst_lcd_rs", lcd_rs, 0);
    rst = 1'b0;
    z = cyc;
    tick();
    strobes.delete();
    last_fall = -1000;
    last_change = cyc;
    mon_en = 1'b1;
    check_init(z);
    xfer(1'b1, 8'h41, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
